// File: rtl/result_memory_rd_if.sv
// Output element port of the result memory reader.
// out_valid/out_ready handshake carrying one complex element per transfer.
// Fields: out_real, out_imag (WORD_LEN), out_row, out_col (RC_BITS), out_last.
// The master modport drives the element; the slave modport returns out_ready.
interface result_memory_rd_if #(
  parameter int unsigned WORD_LEN = 16,
  parameter int unsigned RC_BITS  = 2
);
  logic                out_valid;
  logic                out_ready;
  logic [WORD_LEN-1:0] out_real;
  logic [WORD_LEN-1:0] out_imag;
  logic [RC_BITS-1:0]  out_row;
  logic [RC_BITS-1:0]  out_col;
  logic                out_last;

  modport master (
    output out_valid, out_real, out_imag, out_row, out_col, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_real, out_imag, out_row, out_col, out_last,
    output out_ready
  );
endinterface

// File: rtl/result_memory_rd.sv
// Result memory read side: collects MATRIX_DIM^2 real then MATRIX_DIM^2
// imaginary coefficients from the serial we_final/coefficient stream, then
// drains the complex matrix in row-major order over a valid/ready port.
// Ports:
//   src_clk, rst        clock, asynchronous active-low reset
//   clear               synchronous abort back to FILL_RE
//   we_final/coefficient coefficient strobe and data
//   out_if (master)     element handshake: valid/ready, real, imag, row, col, last
//   state               00 FILL_RE, 01 FILL_IM, 10 DRAIN
//   overrun             sticky flag: strobe dropped during DRAIN
module result_memory_rd #(
  parameter int unsigned WORD_LEN   = 16,
  parameter int unsigned MATRIX_DIM = 4,
  parameter int unsigned IDX_BITS   = 4,
  parameter int unsigned RC_BITS    = 2
) (
  input  logic                src_clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                we_final,
  input  logic [WORD_LEN-1:0] coefficient,
  result_memory_rd_if.master  out_if,
  output logic [1:0]          state,
  output logic                overrun
);

  localparam int unsigned DEPTH = MATRIX_DIM * MATRIX_DIM;
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(DEPTH - 1);

  typedef enum logic [1:0] {
    FILL_RE = 2'b00,
    FILL_IM = 2'b01,
    DRAIN   = 2'b10,
    UNUSED  = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_BITS-1:0] wr_cnt_q, wr_cnt_d;
  logic [IDX_BITS-1:0] rd_cnt_q, rd_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic [WORD_LEN-1:0] out_real_q, out_real_d;
  logic [WORD_LEN-1:0] out_imag_q, out_imag_d;
  logic [RC_BITS-1:0]  out_row_q, out_row_d;
  logic [RC_BITS-1:0]  out_col_q, out_col_d;
  logic                overrun_q, overrun_d;
  logic                re_we_c, im_we_c;

  logic [WORD_LEN-1:0] re_q [DEPTH];
  logic [WORD_LEN-1:0] im_q [DEPTH];

  // Next-state and output-register logic.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_real_d  = out_real_q;
    out_imag_d  = out_imag_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    overrun_d   = overrun_q;
    re_we_c     = 1'b0;
    im_we_c     = 1'b0;

    if (clear) begin
      state_d     = FILL_RE;
      wr_cnt_d    = '0;
      rd_cnt_d    = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      overrun_d   = 1'b0;
    end else begin
      case (state_q)
        FILL_RE: begin
          if (we_final) begin
            re_we_c = 1'b1;
            if (wr_cnt_q == LAST_IDX) begin
              wr_cnt_d = '0;
              state_d  = FILL_IM;
            end else begin
              wr_cnt_d = wr_cnt_q + IDX_BITS'(1);
            end
          end
        end
        FILL_IM: begin
          if (we_final) begin
            im_we_c = 1'b1;
            if (wr_cnt_q == LAST_IDX) begin
              wr_cnt_d = '0;
              rd_cnt_d = '0;
              state_d  = DRAIN;
            end else begin
              wr_cnt_d = wr_cnt_q + IDX_BITS'(1);
            end
          end
        end
        DRAIN: begin
          if (we_final) overrun_d = 1'b1;
          // Load element rd_cnt on the first drain cycle and after each
          // non-final transfer; the final transfer ends the drain.
          if (out_valid_q && out_if.out_ready && out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            rd_cnt_d    = '0;
            state_d     = FILL_RE;
          end else if (!out_valid_q || out_if.out_ready) begin
            out_valid_d = 1'b1;
            out_real_d  = re_q[rd_cnt_q];
            out_imag_d  = im_q[rd_cnt_q];
            out_row_d   = RC_BITS'(rd_cnt_q >> RC_BITS);
            out_col_d   = RC_BITS'(rd_cnt_q);
            out_last_d  = (rd_cnt_q == LAST_IDX);
            rd_cnt_d    = rd_cnt_q + IDX_BITS'(1);
          end
        end
        default: state_d = FILL_RE;
      endcase
    end
  end

  // Control and output registers.
  always_ff @(posedge src_clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FILL_RE;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_real_q  <= '0;
      out_imag_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_real_q  <= out_real_d;
      out_imag_q  <= out_imag_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      overrun_q   <= overrun_d;
    end
  end

  // Coefficient banks; contents survive reset and clear.
  always_ff @(posedge src_clk) begin
    if (re_we_c) re_q[wr_cnt_q] <= coefficient;
    if (im_we_c) im_q[wr_cnt_q] <= coefficient;
  end

  assign out_if.out_valid = out_valid_q;
  assign out_if.out_last  = out_last_q;
  assign out_if.out_real  = out_real_q;
  assign out_if.out_imag  = out_imag_q;
  assign out_if.out_row   = out_row_q;
  assign out_if.out_col   = out_col_q;
  assign state            = state_q;
  assign overrun          = overrun_q;

endmodule

// File: doc/result_memory_rd.md
# result_memory_rd

Collector and reader at the output end of the complex matrix-multiply datapath. Captures the serial `coefficient` stream qualified by `we_final`, which carries MATRIX_DIM² real-part coefficients followed by MATRIX_DIM² imaginary-part coefficients. It stores both parts in an internal result buffer, then drains the complete complex result matrix in row-major order over a valid/ready port. It is the read side of the result memory fed by the Sum_Block output.

## Interface
- WORD_LEN, 16: coefficient width, signed two's complement, same as `` `WORD_LEN ``.
- MATRIX_DIM, 4: matrix dimension; buffer depth per bank = MATRIX_DIM² = 16.
- IDX_BITS, 4: log2(MATRIX_DIM²); width of internal fill/drain counters.
- RC_BITS, 2: log2(MATRIX_DIM); width of row/col outputs.

Ports (clock and reset first):
- src_clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous abort; returns the block to FILL_RE and clears all counters and flags.
- we_final  in  1  coefficient strobe; one pulse per coefficient.
- coefficient  in  WORD_LEN  signed coefficient, sampled when we_final=1.
- out_valid  out  1  out_* fields hold a valid complex element.
- out_ready  in  1  consumer accepts the element.
- out_real  out  WORD_LEN  real part of element.
- out_imag  out  WORD_LEN  imaginary part of element.
- out_row  out  RC_BITS  row index of element.
- out_col  out  RC_BITS  column index of element.
- out_last  out  1  element is index MATRIX_DIM²-1.
- state  out  2  00 FILL_RE, 01 FILL_IM, 10 DRAIN.
- overrun  out  1  sticky: a we_final pulse arrived during DRAIN and was dropped.

## Operation
- Storage: two banks (re, im) of MATRIX_DIM² × WORD_LEN registers, with a shared write counter wr_cnt and a read counter rd_cnt.
- FILL_RE:
  - On each edge with we_final=1, write re[wr_cnt] ← coefficient and increment wr_cnt.
  - At the write with wr_cnt = MATRIX_DIM²-1, wr_cnt wraps to 0 and state → FILL_IM.
- FILL_IM:
  - Same behaviour into the im bank.
  - At the last write, state → DRAIN and rd_cnt ← 0.
- DRAIN:
  - Output registers load element k: out_real=re[k], out_imag=im[k], out_row=k/MATRIX_DIM, out_col=k%MATRIX_DIM, out_last=(k==MATRIX_DIM²-1).
  - Transfer occurs on any edge with out_valid && out_ready. At that edge the output registers load element k+1.
  - Transfer of the out_last element: out_valid ← 0, rd_cnt ← 0, state → FILL_RE.
  - we_final=1 in DRAIN, including the final-transfer cycle: coefficient is dropped and overrun ← 1.
- Unused state encoding 11 returns to FILL_RE on the next edge.
- Priority: rst > clear > normal operation.
  - clear zeroes wr_cnt, rd_cnt, out_valid, out_last and overrun, and sets state to FILL_RE.
  - clear does not zero the buffer contents.
  - A we_final in the same cycle as clear is dropped.
- Arithmetic: data are stored and returned bit-exact. No rounding, saturation or sign manipulation.

## Timing
- Reset values (asserted asynchronously while rst=0):
  - state=FILL_RE; wr_cnt=rd_cnt=0.
  - out_valid=0, out_last=0, overrun=0.
  - out_real=out_imag=0, out_row=out_col=0.
  - Buffer contents are not reset.
- Write latency: coefficient is stored at the same edge where we_final=1. Back-to-back strobes are accepted every cycle.
- Let edge N be the final imaginary write. Then state=DRAIN after edge N, and out_valid=1 with element 0 after edge N+1 (one registered read cycle).
- Throughput: with out_ready held high, one element per cycle, so 16 elements on edges N+2 … N+17. out_valid=0 and state=FILL_RE after edge N+17.
- Backpressure: while out_valid && !out_ready, all out_* fields are held stable.
- out_valid never deasserts without a transfer, except on rst or clear.
- A rst assertion mid-DRAIN drops out_valid immediately, without waiting for a clock edge.
- A FILL_RE write can occur on the edge immediately after the final transfer.

## Test plan
- Fill and drain: reset, then 16 strobes with re values 0..15, then 16 strobes with im values −1..−16, out_ready=1 → elements k=0..15 appear on consecutive cycles.
  - Each element is (k, −k−1), row=k>>2, col=k&3.
  - out_valid rises 2 cycles after the last strobe; out_last on k=15 only.
- Backpressure: as above, with out_ready toggling 1,0,0,1 → each element is held stable while ready=0, there are no duplicates or skips, and exactly 16 transfers occur.
- Overrun: 3 strobes during DRAIN → those coefficients are not stored, drained data are unchanged, and overrun=1 until clear.
- Clear mid-fill: 7 re strobes, then clear, then a full 32-strobe sequence → drained data come only from the post-clear sequence and state returns to 00.
- Async reset mid-drain: assert rst after 5 transfers → out_valid=0 and state=00 before the next edge. After release, a fresh fill and drain behaves normally.
- Extremes: coefficient 0x8000 and 0x7FFF in both banks → returned bit-exact at the correct row/col.
